// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and grant selection for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

    // On a conflict the side that was not served last wins.
    function automatic gnt_t pick_grant(input logic if_req, input logic dm_req, input gnt_t last);
        if (if_req && dm_req) begin
            return (last == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (if_req) begin
            return GNT_IF;
        end
        return GNT_DM;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - busy-cycle counter that flags the last cycle before abort
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // Fires during the TIMEOUT_CYCLES-th ack-less busy cycle so the FSM leaves BUSY at that edge.
    assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one req/ack memory port between fetch and data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst,
    input  logic                  in_if_req,
    input  logic [DATA_WIDTH-1:0] in_if_addr,
    output logic [31:0]           out_if_inst,
    output logic                  out_if_valid,
    output logic                  out_if_err,
    input  logic                  in_dm_req,
    input  logic                  in_dm_wr_en,
    input  logic [DATA_WIDTH-1:0] in_dm_addr,
    input  logic [DATA_WIDTH-1:0] in_dm_wr_data,
    output logic [DATA_WIDTH-1:0] out_dm_rd_data,
    output logic                  out_dm_valid,
    output logic                  out_dm_err,
    output logic                  out_mem_req,
    output logic [DATA_WIDTH-1:0] out_mem_addr,
    output logic                  out_mem_wr_en,
    output logic [DATA_WIDTH-1:0] out_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] in_mem_rd_data,
    input  logic                  in_mem_ack
);

    state_t state, state_nxt;
    gnt_t   last_grant;
    gnt_t   grant;
    logic   do_grant;
    logic   finish;
    logic   timed_out;
    logic   busy;
    logic   expire;

    assign busy = (state == ST_BUSY_IF) || (state == ST_BUSY_DM);

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (in_Clk),
        .rst    (in_Rst),
        .clear  (do_grant),
        .enable (busy && !in_mem_ack),
        .expire (expire)
    );

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = GNT_IF;
        do_grant  = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_if_req || in_dm_req) begin
                    do_grant  = 1'b1;
                    grant     = pick_grant(in_if_req, in_dm_req, last_grant);
                    state_nxt = (grant == GNT_IF) ? ST_BUSY_IF : ST_BUSY_DM;
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                // A real ack in the expiry cycle takes precedence over the abort.
                if (in_mem_ack) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end else if (expire) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            last_grant      <= GNT_DM;
            out_if_inst     <= '0;
            out_if_valid    <= 1'b0;
            out_if_err      <= 1'b0;
            out_dm_rd_data  <= '0;
            out_dm_valid    <= 1'b0;
            out_dm_err      <= 1'b0;
            out_mem_req     <= 1'b0;
            out_mem_addr    <= '0;
            out_mem_wr_en   <= 1'b0;
            out_mem_wr_data <= '0;
        end else begin
            out_if_valid <= 1'b0;
            out_if_err   <= 1'b0;
            out_dm_valid <= 1'b0;
            out_dm_err   <= 1'b0;
            if (do_grant) begin
                out_mem_req <= 1'b1;
                if (grant == GNT_IF) begin
                    out_mem_addr    <= in_if_addr;
                    out_mem_wr_en   <= 1'b0;
                    out_mem_wr_data <= '0;
                end else begin
                    out_mem_addr    <= in_dm_addr;
                    out_mem_wr_en   <= in_dm_wr_en;
                    out_mem_wr_data <= in_dm_wr_data;
                end
            end
            if (finish) begin
                out_mem_req <= 1'b0;
                if (state == ST_BUSY_IF) begin
                    last_grant   <= GNT_IF;
                    out_if_valid <= 1'b1;
                    out_if_err   <= timed_out;
                    if (timed_out) begin
                        out_if_inst <= '0;
                    end else if (out_mem_addr[2]) begin
                        out_if_inst <= in_mem_rd_data[32 +: 32];
                    end else begin
                        out_if_inst <= in_mem_rd_data[0 +: 32];
                    end
                end else begin
                    last_grant     <= GNT_DM;
                    out_dm_valid   <= 1'b1;
                    out_dm_err     <= timed_out;
                    out_dm_rd_data <= (timed_out || out_mem_wr_en) ? '0 : in_mem_rd_data;
                end
            end
        end
    end

endmodule
